// File: rtl/fc_argmax.sv
// fc_argmax: buffers N layer outputs, scans one per cycle for the argmax, reports index, raw and saturated value
module fc_argmax #(
  parameter int WIDTH = 8,
  parameter int ZW    = WIDTH*2+7,
  parameter int N     = 10,
  parameter int SHIFT = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ZW-1:0]   z [N],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] class_idx,
  output logic [ZW-1:0]   max_val,
  output logic [WIDTH-1:0] max_q
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [ZW-1:0]    zbuf_q [N];
  logic [IDXW-1:0]  cnt_q, best_idx_q, class_idx_q, cand_idx;
  logic [ZW-1:0]    best_val_q, max_val_q, cand_val, shifted;
  logic [WIDTH-1:0] maxq_q, sat;
  logic             gt, last;
  always_comb begin
    gt       = zbuf_q[cnt_q] > best_val_q;
    cand_val = gt ? zbuf_q[cnt_q] : best_val_q;
    cand_idx = gt ? cnt_q : best_idx_q;
    last     = cnt_q == IDXW'(N-1);
    shifted  = cand_val >> SHIFT;
    sat      = |(shifted >> WIDTH) ? '1 : shifted[WIDTH-1:0];
    state_d  = (state_q == IDLE && in_valid)  ? SCAN :
               (state_q == SCAN && last)      ? DONE :
               (state_q == DONE && out_ready) ? IDLE : state_q;
  end
  // Results land on the final scan edge, so they are stable for the whole DONE window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      zbuf_q      <= '{default: '0};
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      maxq_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        zbuf_q     <= z;
        best_val_q <= z[0];
        best_idx_q <= '0;
        cnt_q      <= IDXW'(1);
      end
      if (state_q == SCAN) begin
        best_val_q <= cand_val;
        best_idx_q <= cand_idx;
        cnt_q      <= cnt_q + IDXW'(1);
        if (last) begin
          class_idx_q <= cand_idx;
          max_val_q   <= cand_val;
          maxq_q      <= sat;
        end
      end
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;
  assign max_q     = maxq_q;
endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Sequential classifier stage directly downstream of the final fully-connected layer.
- Captures the N post-ReLU neuron outputs in one valid/ready handshake, then scans them one per cycle.
- Reports the winning class index, its raw accumulator value, and a requantized WIDTH-bit copy of that value.
- The result is presented to the consumer through a valid/ready handshake.

Parameters:
- WIDTH, 8, activation bit width of the network; also the width of max_q.
- ZW, WIDTH*2+7, width of each layer output (23 for WIDTH=8).
- N, 10, number of neurons/classes; legal values are N >= 2.
- SHIFT, 8, right-shift applied before saturating to WIDTH bits.
- IDXW, $clog2(N), class index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  z holds a valid vector.
- in_ready  output  1  block can accept a vector.
- z  input  [ZW-1:0] x [0:N-1]  unpacked array of neuron outputs, unsigned (post-ReLU).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- class_idx  output  IDXW  index of the maximum element.
- max_val  output  ZW  value of the maximum element.
- max_q  output  WIDTH  min(max_val >> SHIFT, 2^WIDTH-1).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0.
  - class_idx=0, max_val=0, max_q=0.
  - Capture registers and counter cleared.
  - Reset asserted mid-scan or in DONE aborts the operation; no result is emitted.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge t: register all N inputs into buf, best_val<=z[0], best_idx<=0, cnt<=1, go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle: if buf[cnt] > best_val (strict unsigned compare), best_val<=buf[cnt] and best_idx<=cnt.
  - cnt increments each cycle. After the compare at cnt==N-1, go to DONE.
  - SCAN lasts exactly N-1 cycles.
- DONE:
  - out_valid=1. class_idx, max_val and max_q are registered and stable while out_valid=1.
  - in_ready=0.
  - On out_valid&&out_ready: go to IDLE and drop out_valid the next cycle.
- Latency: out_valid rises at edge t+N-1 after the accepting edge t (edge t+9 for N=10).
- Throughput: one vector per N+1 cycles minimum, with out_ready held high.
- Ties: the lowest index wins (strict compare). An all-zero vector gives class_idx=0, max_val=0.
- Input isolation: z changing after acceptance has no effect on the result (buffered). in_valid asserted outside IDLE is ignored; no handshake occurs because in_ready=0.
- max_q:
  - Computed from the final best_val when entering DONE.
  - shifted = best_val >> SHIFT (logical).
  - If shifted[ZW-1-SHIFT:WIDTH] is nonzero, max_q=2^WIDTH-1; else max_q=shifted[WIDTH-1:0].
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Outputs are registers only; no combinational path from any input to any output.
- The ZW-bit compare is a single comparator plus an N:1 mux indexed by cnt.

Test Plan:
1. Basic scan: reset, then send z={5,9,3,200,7,0,1,2,4,6}, out_ready=1 -> out_valid rises 9 cycles after accept; class_idx=3, max_val=200, max_q=0 (200>>8).
2. Tie and all-zero:
   - z with elements 2 and 7 both equal to 0x1234, others smaller -> class_idx=2, max_q=0x12.
   - All-zero vector -> class_idx=0, max_val=0.
3. Saturation: z[9]=0x7FFFFF, others 0 -> class_idx=9, max_val=0x7FFFFF, max_q=0xFF. z[0]=0xFFFF -> max_q=0xFF. z[0]=0xFEFF -> max_q=0xFE.
4. Handshake:
   - Hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0.
   - Toggle z and in_valid during SCAN -> result unchanged.
   - Raise out_ready -> IDLE next cycle.
   - Back-to-back vectors with out_ready=1 -> second accept no earlier than 11 cycles after the first.
5. Reset mid-operation: assert rst_n=0 asynchronously at SCAN cycle 4 -> out_valid=0, outputs 0 immediately. After release, a new vector {0,...,0,50 at index 1} -> class_idx=1, max_val=50.
6. Random regression: 1000 random vectors with random out_ready stalls -> class_idx, max_val and max_q match a reference argmax model with lowest-index tie-break.
